// File: rtl/ps2_scancode_pkg.sv
// Shared PS/2 set-2 scancode constants, entry FSM encoding and BCD helpers for the
// parameter-entry controller.
package ps2_scancode_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Indexed by digit value.
  localparam logic [7:0] SC_DIGIT [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
  };
  localparam logic [7:0] SC_KP_DIGIT [10] = '{
    8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
  };

  typedef enum logic [1:0] {
    S_MAKE,
    S_BREAK,
    S_EXT,
    S_EXT_BREAK
  } ps2_state_e;

  typedef logic [3:0] bcd_digit_t;

  // Up to four BCD digits, least significant digit in [3:0].
  function automatic int unsigned bcd_to_bin(input logic [15:0] bcd);
    int unsigned acc;
    acc = 0;
    for (int i = 3; i >= 0; i--) begin
      acc = acc * 32'd10 + 32'(bcd[4*i +: 4]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/ps2_param_entry_ctrl_if.sv
// Byte stream from the PS/2 receiver and the committed-parameter / display outputs.
interface ps2_param_entry_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned VALUE_W    = 10
);
  logic [7:0]              received_data;
  logic                    received_data_en;
  logic [VALUE_W-1:0]      param_value;
  logic                    param_valid;
  logic                    entry_error;
  logic [4*NUM_DIGITS-1:0] entry_bcd;
  logic [2:0]              digit_count;
  logic                    entry_active;

  modport master (
    output received_data, received_data_en,
    input  param_value, param_valid, entry_error, entry_bcd, digit_count, entry_active
  );

  modport slave (
    input  received_data, received_data_en,
    output param_value, param_valid, entry_error, entry_bcd, digit_count, entry_active
  );
endinterface

// File: rtl/ps2_scancode_decode.sv
// Combinational make-code classifier. Define PS2_KEYPAD_EN to accept keypad digits and
// keypad Enter (E0 5A).
module ps2_scancode_decode
  import ps2_scancode_pkg::*;
(
  input  logic [7:0] code_i,
  input  logic       ext_i,
  output logic       is_digit_o,
  output bcd_digit_t digit_o,
  output logic       is_enter_o,
  output logic       is_bksp_o,
  output logic       is_esc_o
);

  always_comb begin
    is_digit_o = 1'b0;
    digit_o    = '0;
    is_enter_o = 1'b0;
    is_bksp_o  = 1'b0;
    is_esc_o   = 1'b0;
    if (!ext_i) begin
      for (int i = 0; i < 10; i++) begin
        if (code_i == SC_DIGIT[i]) begin
          is_digit_o = 1'b1;
          digit_o    = bcd_digit_t'(i);
        end
`ifdef PS2_KEYPAD_EN
        if (code_i == SC_KP_DIGIT[i]) begin
          is_digit_o = 1'b1;
          digit_o    = bcd_digit_t'(i);
        end
`endif
      end
      is_enter_o = (code_i == SC_ENTER);
      is_bksp_o  = (code_i == SC_BKSP);
      is_esc_o   = (code_i == SC_ESC);
    end
`ifdef PS2_KEYPAD_EN
    else begin
      is_enter_o = (code_i == SC_ENTER);
    end
`endif
  end

endmodule

// File: rtl/ps2_param_entry_ctrl.sv
// PS/2 keyboard decimal entry controller: buffers digits, commits range-checked values on
// Enter and abandons idle entries. Optional keypad support via PS2_KEYPAD_EN.
module ps2_param_entry_ctrl #(
  parameter int unsigned NUM_DIGITS     = 3,
  parameter int unsigned VALUE_W        = 10,
  parameter int unsigned MAX_VALUE      = 999,
  parameter int unsigned DEFAULT_VALUE  = 0,
  parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
  input logic                   CLOCK_50,
  input logic                   reset,
  ps2_param_entry_ctrl_if.slave bus
);
  import ps2_scancode_pkg::*;

  localparam int unsigned BcdW = 4 * NUM_DIGITS;

  ps2_state_e         state_q, state_d;
  logic [BcdW-1:0]    bcd_q, bcd_d;
  logic [2:0]         count_q, count_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;
  logic               active_q, active_d;
  logic [31:0]        tmo_q, tmo_d;

  logic        is_digit, is_enter, is_bksp, is_esc, key_ok;
  bcd_digit_t  digit;
  int unsigned entry_val;

  ps2_scancode_decode u_decode (
    .code_i     (bus.received_data),
    .ext_i      (state_q == S_EXT),
    .is_digit_o (is_digit),
    .digit_o    (digit),
    .is_enter_o (is_enter),
    .is_bksp_o  (is_bksp),
    .is_esc_o   (is_esc)
  );

  // Unused upper digits are always zero, so the full buffer converts directly.
  assign entry_val = bcd_to_bin(16'(bcd_q));

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    count_d = count_q;
    value_d = value_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    tmo_d   = tmo_q;
    key_ok  = 1'b0;
    if (bus.received_data_en) begin
      tmo_d = '0;
      unique case (state_q)
        S_MAKE: begin
          if (bus.received_data == SC_BREAK)    state_d = S_BREAK;
          else if (bus.received_data == SC_EXT) state_d = S_EXT;
          else                                  key_ok  = 1'b1;
        end
        S_EXT: begin
          if (bus.received_data == SC_BREAK) begin
            state_d = S_EXT_BREAK;
          end else begin
            key_ok  = 1'b1;
            state_d = S_MAKE;
          end
        end
        default: state_d = S_MAKE;
      endcase
      if (key_ok) begin
        if (is_digit) begin
          if (count_q < 3'(NUM_DIGITS)) begin
            bcd_d   = (bcd_q << 4) | BcdW'(digit);
            count_d = count_q + 3'd1;
          end
        end else if (is_bksp) begin
          if (count_q != 3'd0) begin
            bcd_d   = bcd_q >> 4;
            count_d = count_q - 3'd1;
          end
        end else if (is_esc) begin
          bcd_d   = '0;
          count_d = '0;
        end else if (is_enter && count_q != 3'd0) begin
          if (entry_val > MAX_VALUE) begin
            error_d = 1'b1;
          end else begin
            value_d = VALUE_W'(entry_val);
            valid_d = 1'b1;
          end
          bcd_d   = '0;
          count_d = '0;
        end
      end
    end else if (count_q != 3'd0 && TIMEOUT_CYCLES != 0) begin
      if (tmo_q == TIMEOUT_CYCLES - 1) begin
        bcd_d   = '0;
        count_d = '0;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end else begin
      tmo_d = '0;
    end
    active_d = (count_d != 3'd0);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_MAKE;
      bcd_q    <= '0;
      count_q  <= '0;
      value_q  <= VALUE_W'(DEFAULT_VALUE);
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      active_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      count_q  <= count_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      active_q <= active_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.param_value  = value_q;
  assign bus.param_valid  = valid_q;
  assign bus.entry_error  = error_q;
  assign bus.entry_bcd    = bcd_q;
  assign bus.digit_count  = count_q;
  assign bus.entry_active = active_q;

endmodule

// File: tb/tb_ps2_param_entry_ctrl.sv
// Directed bench for ps2_param_entry_ctrl; commit/reject pulses are checked against a
// queue of expected outcomes. Expectations follow PS2_KEYPAD_EN when it is defined.
module tb_ps2_param_entry_ctrl;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_val;

  typedef struct packed {
    logic       is_err;
    logic [9:0] val;
  } exp_t;
  exp_t exp_q[$];

  ps2_param_entry_ctrl_if #(.NUM_DIGITS(3), .VALUE_W(10)) bus ();

  ps2_param_entry_ctrl #(
    .NUM_DIGITS     (3),
    .VALUE_W        (10),
    .MAX_VALUE      (500),
    .DEFAULT_VALUE  (7),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.received_data    = b;
    bus.received_data_en = 1'b1;
    @(posedge clk);
    #1;
    bus.received_data_en = 1'b0;
  endtask

  task automatic expect_commit(input logic is_err, input logic [9:0] v);
    exp_t e;
    e.is_err = is_err;
    e.val    = v;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every commit/reject pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && (bus.param_valid || bus.entry_error)) begin
      exp_t e;
      chk("valid_error_excl", 32'(bus.param_valid & bus.entry_error), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'({bus.param_valid, bus.entry_error}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("commit_kind", 32'(bus.entry_error), 32'(e.is_err));
        chk("commit_value", 32'(bus.param_value), 32'(e.val));
      end
    end
  end

  initial begin
    bus.received_data    = 8'h00;
    bus.received_data_en = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("rst_value", 32'(bus.param_value), 32'd7);
    chk("rst_valid", 32'(bus.param_valid), 32'd0);
    chk("rst_error", 32'(bus.entry_error), 32'd0);
    chk("rst_bcd", 32'(bus.entry_bcd), 32'h000);
    chk("rst_count", 32'(bus.digit_count), 32'd0);
    chk("rst_active", 32'(bus.entry_active), 32'd0);

    // 1, 2, 0 with break codes interleaved.
    send(8'h16); send(8'hF0); send(8'h16);
    send(8'h1E); send(8'hF0); send(8'h1E);
    send(8'h45); send(8'hF0); send(8'h45);
    chk("t1_bcd", 32'(bus.entry_bcd), 32'h120);
    chk("t1_count", 32'(bus.digit_count), 32'd3);
    chk("t1_active", 32'(bus.entry_active), 32'd1);
    expect_commit(1'b0, 10'd120);
    send(8'h5A);
    chk("t1_valid", 32'(bus.param_valid), 32'd1);
    chk("t1_value", 32'(bus.param_value), 32'd120);
    chk("t1_bcd_clr", 32'(bus.entry_bcd), 32'h000);
    tick(1);
    chk("t1_valid_1cyc", 32'(bus.param_valid), 32'd0);

    // Overflowing digit ignored, backspace, commit.
    send(8'h46); send(8'h46); send(8'h46);
    chk("t2_bcd_full", 32'(bus.entry_bcd), 32'h999);
    send(8'h46);
    chk("t2_bcd_4th", 32'(bus.entry_bcd), 32'h999);
    chk("t2_count_4th", 32'(bus.digit_count), 32'd3);
    send(8'h66);
    chk("t2_bcd_bksp", 32'(bus.entry_bcd), 32'h099);
    chk("t2_count_bksp", 32'(bus.digit_count), 32'd2);
    expect_commit(1'b0, 10'd99);
    send(8'h5A);
    chk("t2_value", 32'(bus.param_value), 32'd99);

    // Range boundary: 500 accepted, 501 and 600 rejected.
    send(8'h2E); send(8'h45); send(8'h45);
    expect_commit(1'b0, 10'd500);
    send(8'h5A);
    chk("t3_500", 32'(bus.param_value), 32'd500);
    send(8'h2E); send(8'h45); send(8'h16);
    expect_commit(1'b1, 10'd500);
    send(8'h5A);
    chk("t3_501_err", 32'(bus.entry_error), 32'd1);
    chk("t3_501_valid", 32'(bus.param_valid), 32'd0);
    chk("t3_501_keep", 32'(bus.param_value), 32'd500);
    send(8'h36); send(8'h45); send(8'h45);
    expect_commit(1'b1, 10'd500);
    send(8'h5A);
    chk("t3_600_err", 32'(bus.entry_error), 32'd1);
    chk("t3_600_count", 32'(bus.digit_count), 32'd0);
    last_val = 500;

    // Empty-buffer edit keys and escape.
    send(8'h66);
    chk("t4_bksp_empty", 32'(bus.digit_count), 32'd0);
    send(8'h5A);
    chk("t4_enter_empty", 32'({bus.param_valid, bus.entry_error}), 32'd0);
    send(8'h26); send(8'h26); send(8'h76);
    chk("t4_esc_bcd", 32'(bus.entry_bcd), 32'h000);
    chk("t4_esc_count", 32'(bus.digit_count), 32'd0);

    // Timeout expiry, strobe coinciding with expiry, and counter clear on any byte.
    send(8'h26);
    tick(99);
    chk("t5_pre_expiry", 32'(bus.digit_count), 32'd1);
    tick(1);
    chk("t5_expired", 32'(bus.digit_count), 32'd0);
    chk("t5_expired_bcd", 32'(bus.entry_bcd), 32'h000);
    chk("t5_expired_val", 32'(bus.param_value), 32'(last_val));
    send(8'h26);
    tick(99);
    send(8'h2E);
    chk("t5_coincide_bcd", 32'(bus.entry_bcd), 32'h035);
    chk("t5_coincide_count", 32'(bus.digit_count), 32'd2);
    send(8'h76);
    send(8'h26);
    tick(60);
    send(8'h1C);
    tick(60);
    chk("t5_restart", 32'(bus.digit_count), 32'd1);
    send(8'h76);

    // Keypad digit and extended codes.
    send(8'h69);
`ifdef PS2_KEYPAD_EN
    chk("t6_kp_count", 32'(bus.digit_count), 32'd1);
    expect_commit(1'b0, 10'd1);
    send(8'h5A);
    chk("t6_kp_commit", 32'(bus.param_value), 32'd1);
    last_val = 1;
`else
    chk("t6_kp_ignored", 32'(bus.digit_count), 32'd0);
    send(8'h5A);
    chk("t6_kp_nocommit", 32'(bus.param_value), 32'(last_val));
`endif
    send(8'h1E);
    send(8'hE0); send(8'h16);
    chk("t6_ext_make_drop", 32'(bus.digit_count), 32'd1);
    chk("t6_ext_make_bcd", 32'(bus.entry_bcd), 32'h002);
    send(8'hE0); send(8'hF0); send(8'h5A);
    chk("t6_ext_break_drop", 32'(bus.digit_count), 32'd1);
`ifdef PS2_KEYPAD_EN
    expect_commit(1'b0, 10'd2);
    send(8'hE0); send(8'h5A);
    chk("t6_kp_enter_val", 32'(bus.param_value), 32'd2);
    chk("t6_kp_enter_cnt", 32'(bus.digit_count), 32'd0);
    last_val = 2;
`else
    send(8'hE0); send(8'h5A);
    chk("t6_ext_enter_val", 32'(bus.param_value), 32'(last_val));
    chk("t6_ext_enter_cnt", 32'(bus.digit_count), 32'd1);
`endif
    send(8'h76);

    // Reset with a break prefix pending.
    send(8'h25); send(8'hF0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t7_rst_value", 32'(bus.param_value), 32'd7);
    chk("t7_rst_count", 32'(bus.digit_count), 32'd0);
    chk("t7_rst_bcd", 32'(bus.entry_bcd), 32'h000);
    chk("t7_rst_active", 32'(bus.entry_active), 32'd0);
    send(8'h25);
    chk("t7_make_count", 32'(bus.digit_count), 32'd1);
    chk("t7_make_bcd", 32'(bus.entry_bcd), 32'h004);

    tick(2);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_param_entry_ctrl.md
Name: ps2_param_entry_ctrl

Overview:
- Sequencing controller between the PS/2 receiver (byte stream plus `received_data_en` strobe) and the amp's parameter registers.
- Parses set-2 scancodes (make, break and extended prefixes) into a NUM_DIGITS-digit decimal entry buffer.
- On Enter, converts the buffer to binary, range-checks it and commits it with a one-cycle valid pulse.
- Provides the BCD buffer and digit count for seven-segment feedback, plus an inactivity timeout that abandons stale entries.

Parameters:
- NUM_DIGITS, 3: maximum decimal digits buffered (range 1..4).
- VALUE_W, 10: width of `param_value`; must hold MAX_VALUE.
- MAX_VALUE, 999: largest committable value; larger entries are rejected.
- DEFAULT_VALUE, 0: `param_value` after reset.
- TIMEOUT_CYCLES, 250000000: idle cycles (5 s at 50 MHz) before a partial entry is cleared; 0 disables the timeout.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- received_data  in  8  scancode byte from the PS/2 receiver
- received_data_en  in  1  one-cycle strobe; `received_data` is valid when high
- param_value  out  VALUE_W  last committed value (registered)
- param_valid  out  1  one-cycle pulse on each successful commit
- entry_error  out  1  one-cycle pulse on a rejected commit (value > MAX_VALUE)
- entry_bcd  out  4*NUM_DIGITS  digit buffer; newest digit in [3:0]; unused digits read 0
- digit_count  out  3  number of digits currently buffered (0..NUM_DIGITS)
- entry_active  out  1  high while digit_count != 0

Behaviour:
- Interface: one clock, CLOCK_50. Reset is synchronous, active-high, port `reset`.
- Reset values: param_value = DEFAULT_VALUE; param_valid = 0; entry_error = 0; entry_bcd = 0; digit_count = 0; entry_active = 0; FSM = S_MAKE; timeout counter = 0.
- Bytes are consumed only on cycles with received_data_en = 1. All outputs are registered, so a byte's effect is visible the cycle after its strobe.
- FSM states: S_MAKE, S_BREAK, S_EXT, S_EXT_BREAK.
  - S_MAKE, byte F0: go to S_BREAK.
  - S_MAKE, byte E0: go to S_EXT.
  - S_MAKE, any other byte: decode it as a make code and stay in S_MAKE.
  - S_BREAK: the next byte (the released key) is discarded; return to S_MAKE.
  - S_EXT, byte F0: go to S_EXT_BREAK.
  - S_EXT, any other byte: handle as an extended make code (see the optional feature); return to S_MAKE.
  - S_EXT_BREAK: the next byte is discarded; return to S_MAKE.
- Digit make codes: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
  - If digit_count < NUM_DIGITS: shift entry_bcd left 4 bits, insert the digit at [3:0], increment digit_count.
  - If the buffer is full: ignore the digit, no error.
  - Typematic repeats are treated as new digits.
- Backspace (66): shift entry_bcd right 4 bits, zero-fill the top digit, decrement digit_count. No-op when the buffer is empty.
- Escape (76): clear entry_bcd and digit_count.
- Enter (5A) with digit_count = 0: ignored, no pulse.
- Enter (5A) with digit_count > 0:
  - Compute value = sum of digit[i] * 10^i.
  - If value <= MAX_VALUE: param_value <= value and param_valid = 1 for one cycle.
  - Otherwise: param_value is unchanged and entry_error = 1 for one cycle.
  - In both cases the buffer is cleared.
  - param_valid and entry_error are never high together.
- All other codes are ignored.
- Timeout:
  - The counter runs only while entry_active = 1 and clears on every received_data_en.
  - On reaching TIMEOUT_CYCLES-1 it clears the buffer, with no pulse.
  - If a byte strobe coincides with expiry, the byte is processed and the timeout is suppressed.
- Reset asserted mid-sequence (for example after F0 or E0) discards the pending prefix and the buffer; param_value returns to DEFAULT_VALUE.

Optional Feature:
- Macro: PS2_KEYPAD_EN.
- Defined:
  - Numeric keypad make codes are accepted as digits: 70=0, 69=1, 72=2, 7A=3, 6B=4, 73=5, 74=6, 6C=7, 75=8, 7D=9.
  - Extended E0 5A (keypad Enter) acts as Enter.
- Undefined: those keypad codes are ignored, and every extended make code is discarded.

Decomposition:
- Package ps2_scancode_pkg holds:
  - scancode constants (SC_BREAK=F0, SC_EXT=E0, SC_ENTER=5A, SC_BKSP=66, SC_ESC=76, the digit codes);
  - the FSM state encoding;
  - the 4-bit BCD digit type.
- Sub-module ps2_scancode_decode: combinational. Maps byte + ext flag to is_digit, digit[3:0], is_enter, is_bksp, is_esc. Contains the PS2_KEYPAD_EN logic.

Test Plan:
- After reset, send 16, F0, 16, 1E, F0, 1E, 45, F0, 45, 5A → param_value = 120; param_valid is one cycle high the cycle after the 5A strobe; entry_bcd = 0 afterwards.
- Send 46, 46, 46, 46 (4th ignored), then 66, then 5A → entry_bcd reads 999 then 099 (digit_count = 2); commit gives param_value = 99.
- With MAX_VALUE = 500, send 36, 45, 45, 5A → entry_error pulses; param_value keeps its prior value; digit_count = 0.
- With TIMEOUT_CYCLES = 100, send 26 and stay idle for 100 cycles → digit_count returns to 0 with no pulse. In a second run, send the next byte exactly at expiry → that byte is processed and the buffer is kept.
- Send E0, 5A → with PS2_KEYPAD_EN: commits the buffer. Without it: no effect. Also send 69, 5A → param_value = 1 only when the macro is defined.
- Send 25, F0, then assert reset for one cycle → all outputs return to reset values; the following byte 25 is treated as a make code (digit_count = 1).
